alu_ctrl_seq: RTL and testbench

Sequencer that drives the 16-bit sliced ALU's control inputs. It accepts one ALU operation per handshake, decodes it into the ALU's arithmetic/logic/shift/LLI control lines, and sequences output-enable and settling. It captures the ALU flag outputs into a flag register that feeds later carry-dependent operations. It sits between the instruction decoder and ALU_16Slice.

---
 rtl/alu_ctrl_pkg.sv | 58 +++++
 rtl/alu_op_decode.sv | 51 +++++
 rtl/alu_ctrl_seq.sv | 155 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU control sequencer: opcode map, FSM state codes and
// the bundle of ALU control lines driven by the sequencer.
package alu_ctrl_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_ADC  = 5'd1,
    OP_SUB  = 5'd2,
    OP_SBC  = 5'd3,
    OP_NEG  = 5'd4,
    OP_MOVB = 5'd5,
    OP_AND  = 5'd6,
    OP_OR   = 5'd7,
    OP_XOR  = 5'd8,
    OP_NOT  = 5'd9,
    OP_NAND = 5'd10,
    OP_NOR  = 5'd11,
    OP_LSL  = 5'd12,
    OP_LSR  = 5'd13,
    OP_ASR  = 5'd14,
    OP_LSRB = 5'd15,
    OP_ASRB = 5'd16,
    OP_LLI  = 5'd17,
    OP_CMP  = 5'd18
  } opcode_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SETUP   = 2'd1;
  localparam state_t ST_EXEC    = 2'd2;
  localparam state_t ST_CAPTURE = 2'd3;

  // All 21 control lines of ALU_16Slice, one field per pin.
  typedef struct packed {
    logic cin;
    logic sub;
    logic zero_a;
    logic fa_out;
    logic l_and;
    logic l_or;
    logic l_xor;
    logic l_not;
    logic l_nand;
    logic l_nor;
    logic sign;
    logic sh_sign_in;
    logic sh1;
    logic sh2;
    logic sh4;
    logic sh8;
    logic sh_b;
    logic sh_l;
    logic sh_r;
    logic sh_out;
    logic lli;
  } ctrl_word_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: turns an opcode, shift amount and the current
// carry flag into ALU control lines plus legality / enable / carry-update bits.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [3:0]  sh_amt,
  input  logic        flag_c,
  output ctrl_word_t  ctrl,
  output logic        legal,
  output logic        use_enable,
  output logic        update_c
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ctrl       = '0;
    legal      = 1'b1;
    use_enable = 1'b1;
    update_c   = 1'b0;

    case (opcode)
      OP_ADD:  begin ctrl.fa_out = 1'b1; update_c = 1'b1; end
      OP_ADC:  begin ctrl.fa_out = 1'b1; ctrl.cin = flag_c; update_c = 1'b1; end
      OP_SUB:  begin ctrl.fa_out = 1'b1; ctrl.sub = 1'b1; update_c = 1'b1; end
      OP_SBC:  begin ctrl.fa_out = 1'b1; ctrl.sub = 1'b1; ctrl.cin = ~flag_c; update_c = 1'b1; end
      OP_NEG:  begin ctrl.fa_out = 1'b1; ctrl.sub = 1'b1; ctrl.zero_a = 1'b1; update_c = 1'b1; end
      OP_MOVB: begin ctrl.fa_out = 1'b1; ctrl.zero_a = 1'b1; end
      OP_AND:  ctrl.l_and  = 1'b1;
      OP_OR:   ctrl.l_or   = 1'b1;
      OP_XOR:  ctrl.l_xor  = 1'b1;
      OP_NOT:  ctrl.l_not  = 1'b1;
      OP_NAND: ctrl.l_nand = 1'b1;
      OP_NOR:  ctrl.l_nor  = 1'b1;
      OP_LSL:  begin ctrl.sh_out = 1'b1; ctrl.sh_l = 1'b1; end
      OP_LSR:  begin ctrl.sh_out = 1'b1; ctrl.sh_r = 1'b1; end
      OP_ASR:  begin ctrl.sh_out = 1'b1; ctrl.sh_r = 1'b1; ctrl.sh_sign_in = 1'b1; end
      OP_LSRB: begin ctrl.sh_out = 1'b1; ctrl.sh_r = 1'b1; ctrl.sh_b = 1'b1; end
      OP_ASRB: begin
        ctrl.sh_out = 1'b1; ctrl.sh_r = 1'b1; ctrl.sh_b = 1'b1; ctrl.sh_sign_in = 1'b1;
      end
      OP_LLI:  ctrl.lli = 1'b1;
      // Compare runs the subtractor for flags only; the result never reaches the bus.
      OP_CMP:  begin ctrl.fa_out = 1'b1; ctrl.sub = 1'b1; update_c = 1'b1; use_enable = 1'b0; end
      default: begin legal = 1'b0; use_enable = 1'b0; end
    endcase

    if (ctrl.sh_out) {ctrl.sh8, ctrl.sh4, ctrl.sh2, ctrl.sh1} = sh_amt;
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Handshake-driven sequencer for ALU_16Slice: SETUP -> EXEC (settle) -> CAPTURE,
// registering the decoded controls and capturing Z/C/N flags at the end of CAPTURE.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       OpValid,
  output logic       OpReady,
  input  logic [4:0] OpCode,
  input  logic [3:0] ShAmt,
  input  logic       ALUOutMSB,
  input  logic       COutIn,
  input  logic       nZIn,
  output logic       CIn,
  output logic       SUB,
  output logic       ZeroA,
  output logic       FAOut,
  output logic       AND,
  output logic       OR,
  output logic       XOR,
  output logic       NOT,
  output logic       NAND,
  output logic       NOR,
  output logic       Sign,
  output logic       ShSignIn,
  output logic       Sh1,
  output logic       Sh2,
  output logic       Sh4,
  output logic       Sh8,
  output logic       ShB,
  output logic       ShL,
  output logic       ShR,
  output logic       ShOut,
  output logic       LLI,
  output logic       ALUEnable,
  output logic       ResultValid,
  output logic       Illegal,
  output logic       FlagZ,
  output logic       FlagC,
  output logic       FlagN
);

  localparam logic [1:0] CNT_LAST = 2'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] cnt;
  ctrl_word_t ctrl_q, dec_ctrl;
  logic       dec_legal, dec_use_en, dec_upd_c;
  logic       legal_q, use_en_q, upd_c_q;
  logic       alu_en_q, res_valid_q, illegal_q;
  logic       flag_z_q, flag_c_q, flag_n_q;

  // Decoded at handshake time, so ADC/SBC see the carry left by the previous op.
  alu_op_decode u_decode (
    .opcode     (OpCode),
    .sh_amt     (ShAmt),
    .flag_c     (flag_c_q),
    .ctrl       (dec_ctrl),
    .legal      (dec_legal),
    .use_enable (dec_use_en),
    .update_c   (dec_upd_c)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ctrl_q      <= '0;
      legal_q     <= 1'b0;
      use_en_q    <= 1'b0;
      upd_c_q     <= 1'b0;
      alu_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_n_q    <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (OpValid) begin
            ctrl_q   <= dec_ctrl;
            legal_q  <= dec_legal;
            use_en_q <= dec_use_en;
            upd_c_q  <= dec_upd_c;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt      <= '0;
          alu_en_q <= use_en_q;
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          if (cnt == CNT_LAST) begin
            res_valid_q <= 1'b1;
            illegal_q   <= ~legal_q;
            state       <= ST_CAPTURE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        ST_CAPTURE: begin
          if (legal_q) begin
            flag_z_q <= ~nZIn;
            flag_n_q <= ALUOutMSB;
            if (upd_c_q) flag_c_q <= COutIn;
          end
          ctrl_q   <= '0;
          alu_en_q <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign OpReady     = (state == ST_IDLE);
  assign ALUEnable   = alu_en_q;
  assign ResultValid = res_valid_q;
  assign Illegal     = illegal_q;
  assign FlagZ       = flag_z_q;
  assign FlagC       = flag_c_q;
  assign FlagN       = flag_n_q;

  assign CIn      = ctrl_q.cin;
  assign SUB      = ctrl_q.sub;
  assign ZeroA    = ctrl_q.zero_a;
  assign FAOut    = ctrl_q.fa_out;
  assign AND      = ctrl_q.l_and;
  assign OR       = ctrl_q.l_or;
  assign XOR      = ctrl_q.l_xor;
  assign NOT      = ctrl_q.l_not;
  assign NAND     = ctrl_q.l_nand;
  assign NOR      = ctrl_q.l_nor;
  assign Sign     = ctrl_q.sign;
  assign ShSignIn = ctrl_q.sh_sign_in;
  assign Sh1      = ctrl_q.sh1;
  assign Sh2      = ctrl_q.sh2;
  assign Sh4      = ctrl_q.sh4;
  assign Sh8      = ctrl_q.sh8;
  assign ShB      = ctrl_q.sh_b;
  assign ShL      = ctrl_q.sh_l;
  assign ShR      = ctrl_q.sh_r;
  assign ShOut    = ctrl_q.sh_out;
  assign LLI      = ctrl_q.lli;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: a small ALU model closes the loop on the flag inputs,
// and an opcode-level reference model predicts controls, result and flags.
module tb_alu_ctrl_seq;

  localparam int SETTLE = 2;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       OpValid = 1'b0;
  logic [4:0] OpCode = '0;
  logic [3:0] ShAmt = '0;
  logic       ALUOutMSB, COutIn, nZIn;
  logic       OpReady, CIn, SUB, ZeroA, FAOut, AND, OR, XOR, NOT, NAND, NOR;
  logic       Sign, ShSignIn, Sh1, Sh2, Sh4, Sh8, ShB, ShL, ShR, ShOut, LLI;
  logic       ALUEnable, ResultValid, Illegal, FlagZ, FlagC, FlagN;

  logic [15:0] op_a = '0, op_b = '0;
  logic [15:0] alu_res, alu_out, fa_a, sh_in;
  logic [16:0] fa_sum;
  logic [3:0]  sh_n;
  logic [20:0] ctrl_vec;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic mdl_z = 1'b0, mdl_c = 1'b0, mdl_n = 1'b0;

  alu_ctrl_seq #(.SETTLE_CYCLES(SETTLE)) dut (
    .Clock(Clock), .Reset(Reset), .OpValid(OpValid), .OpReady(OpReady),
    .OpCode(OpCode), .ShAmt(ShAmt), .ALUOutMSB(ALUOutMSB), .COutIn(COutIn), .nZIn(nZIn),
    .CIn(CIn), .SUB(SUB), .ZeroA(ZeroA), .FAOut(FAOut),
    .AND(AND), .OR(OR), .XOR(XOR), .NOT(NOT), .NAND(NAND), .NOR(NOR),
    .Sign(Sign), .ShSignIn(ShSignIn), .Sh1(Sh1), .Sh2(Sh2), .Sh4(Sh4), .Sh8(Sh8),
    .ShB(ShB), .ShL(ShL), .ShR(ShR), .ShOut(ShOut), .LLI(LLI),
    .ALUEnable(ALUEnable), .ResultValid(ResultValid), .Illegal(Illegal),
    .FlagZ(FlagZ), .FlagC(FlagC), .FlagN(FlagN)
  );

  always #5 Clock = ~Clock;

  assign ctrl_vec = {CIn, SUB, ZeroA, FAOut, AND, OR, XOR, NOT, NAND, NOR,
                     Sign, ShSignIn, Sh1, Sh2, Sh4, Sh8, ShB, ShL, ShR, ShOut, LLI};

  // ALU_16Slice stand-in driven purely by the control lines.
  always_comb begin
    alu_res = '0;
    fa_a    = ZeroA ? 16'h0000 : op_a;
    fa_sum  = '0;
    sh_n    = {Sh8, Sh4, Sh2, Sh1};
    sh_in   = ShB ? {{8{ShSignIn & op_b[7]}}, op_b[7:0]} : op_b;
    if (FAOut) begin
      if (SUB) fa_sum = {1'b0, fa_a} + {1'b0, ~op_b} + {16'b0, ~CIn};
      else     fa_sum = {1'b0, fa_a} + {1'b0, op_b} + {16'b0, CIn};
      alu_res = fa_sum[15:0];
    end
    else if (AND)  alu_res = op_a & op_b;
    else if (OR)   alu_res = op_a | op_b;
    else if (XOR)  alu_res = op_a ^ op_b;
    else if (NOT)  alu_res = ~op_b;
    else if (NAND) alu_res = ~(op_a & op_b);
    else if (NOR)  alu_res = ~(op_a | op_b);
    else if (ShOut) begin
      if (ShL)           alu_res = sh_in << sh_n;
      else if (ShSignIn) alu_res = $signed(sh_in) >>> sh_n;
      else               alu_res = sh_in >> sh_n;
    end
    else if (LLI)  alu_res = {op_a[15:8], op_b[7:0]};
  end

  // Non-adder ops present the inverse of the held carry so a stray C update shows up.
  assign COutIn    = FAOut ? fa_sum[16] : ~mdl_c;
  assign ALUOutMSB = alu_res[15];
  assign nZIn      = |alu_res;
  assign alu_out   = ALUEnable ? alu_res : 16'h0000;

  function automatic logic [15:0] ref_result(input int op, input logic [15:0] a, b,
                                             input logic [3:0] sh, input logic c);
    logic [15:0] bx;
    bx = {{8{b[7]}}, b[7:0]};
    case (op)
      0:     return a + b;
      1:     return a + b + 16'(c);
      2, 18: return a - b;
      3:     return a - b - 16'(!c);
      4:     return 16'h0000 - b;
      5:     return b;
      6:     return a & b;
      7:     return a | b;
      8:     return a ^ b;
      9:     return ~b;
      10:    return ~(a & b);
      11:    return ~(a | b);
      12:    return b << sh;
      13:    return b >> sh;
      14:    return $signed(b) >>> sh;
      15:    return {8'h00, b[7:0]} >> sh;
      16:    return $signed(bx) >>> sh;
      17:    return {a[15:8], b[7:0]};
      default: return 16'h0000;
    endcase
  endfunction

  // Carry out in "1 = no borrow" sense for subtraction.
  function automatic logic ref_carry(input int op, input logic [15:0] a, b, input logic c);
    case (op)
      0:     return (int'(a) + int'(b)) > 65535;
      1:     return (int'(a) + int'(b) + int'(c)) > 65535;
      2, 18: return int'(a) >= int'(b);
      3:     return (int'(a) - int'(b) - int'(!c)) >= 0;
      4:     return b == 16'h0000;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [20:0] exp_ctrl(input int op, input logic [3:0] sh, input logic c);
    logic cin, sub, za, fa, an, orl, xo, nt, nd, nr, shs, shb, shl, shr, sho, lli;
    logic [3:0] amt;
    {cin, sub, za, fa, an, orl, xo, nt, nd, nr, shs, shb, shl, shr, sho, lli} = '0;
    amt = '0;
    case (op)
      0:  fa = 1'b1;
      1:  begin fa = 1'b1; cin = c; end
      2:  begin fa = 1'b1; sub = 1'b1; end
      3:  begin fa = 1'b1; sub = 1'b1; cin = !c; end
      4:  begin fa = 1'b1; sub = 1'b1; za = 1'b1; end
      5:  begin fa = 1'b1; za = 1'b1; end
      6:  an  = 1'b1;
      7:  orl = 1'b1;
      8:  xo  = 1'b1;
      9:  nt  = 1'b1;
      10: nd  = 1'b1;
      11: nr  = 1'b1;
      12: begin sho = 1'b1; shl = 1'b1; end
      13: begin sho = 1'b1; shr = 1'b1; end
      14: begin sho = 1'b1; shr = 1'b1; shs = 1'b1; end
      15: begin sho = 1'b1; shr = 1'b1; shb = 1'b1; end
      16: begin sho = 1'b1; shr = 1'b1; shb = 1'b1; shs = 1'b1; end
      17: lli = 1'b1;
      18: begin fa = 1'b1; sub = 1'b1; end
      default: ;
    endcase
    if (sho) amt = sh;
    return {cin, sub, za, fa, an, orl, xo, nt, nd, nr, 1'b0, shs,
            amt[0], amt[1], amt[2], amt[3], shb, shl, shr, sho, lli};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_flag_z"}, 32'(FlagZ), 32'(mdl_z));
    check({tag, "_flag_c"}, 32'(FlagC), 32'(mdl_c));
    check({tag, "_flag_n"}, 32'(FlagN), 32'(mdl_n));
  endtask

  // Issues one op from an IDLE negedge and checks every cycle through the return to IDLE.
  task automatic run_op(input logic [4:0] op, input logic [3:0] sh,
                        input logic [15:0] a, b, input bit busy_poke);
    int          waited;
    logic        legal, en, new_c;
    logic [20:0] ec;
    logic [15:0] er;
    waited = 0;
    while (!OpReady && waited < 50) begin
      @(negedge Clock);
      waited++;
    end
    check("ready_wait", 32'(OpReady), 32'd1);
    legal = (op <= 5'd18);
    en    = legal && (op != 5'd18);
    ec    = exp_ctrl(int'(op), sh, mdl_c);
    er    = ref_result(int'(op), a, b, sh, mdl_c);
    new_c = ref_carry(int'(op), a, b, mdl_c);
    OpCode = op; ShAmt = sh; op_a = a; op_b = b; OpValid = 1'b1;

    @(negedge Clock);
    OpValid = busy_poke;
    if (busy_poke) begin
      OpCode = 5'($urandom);
      ShAmt  = 4'($urandom);
    end
    check("setup_ctrl", 32'(ctrl_vec), 32'(ec));
    check("setup_en", 32'(ALUEnable), 32'd0);
    check("setup_ready", 32'(OpReady), 32'd0);
    check("setup_valid", 32'(ResultValid), 32'd0);

    repeat (SETTLE) begin
      @(negedge Clock);
      check("exec_ctrl", 32'(ctrl_vec), 32'(ec));
      check("exec_en", 32'(ALUEnable), 32'(en));
      check("exec_valid", 32'(ResultValid), 32'd0);
    end

    @(negedge Clock);
    OpValid = 1'b0;
    check("cap_valid", 32'(ResultValid), 32'd1);
    check("cap_illegal", 32'(Illegal), 32'(!legal));
    check("cap_ctrl", 32'(ctrl_vec), 32'(ec));
    check("cap_en", 32'(ALUEnable), 32'(en));
    if (en) check("cap_result", 32'(alu_out), 32'(er));
    if (legal) begin
      mdl_z = (er == 16'h0000);
      mdl_n = er[15];
      if (op <= 5'd4 || op == 5'd18) mdl_c = new_c;
    end

    @(negedge Clock);
    check("idle_valid", 32'(ResultValid), 32'd0);
    check("idle_ctrl", 32'(ctrl_vec), 32'd0);
    check("idle_en", 32'(ALUEnable), 32'd0);
    check("idle_ready", 32'(OpReady), 32'd1);
    check_flags("idle");
  endtask

  initial begin
    logic [4:0]  r_op;
    logic [15:0] r_a, r_b;

    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check("rst_ready", 32'(OpReady), 32'd1);
    check("rst_ctrl", 32'(ctrl_vec), 32'd0);
    check("rst_en", 32'(ALUEnable), 32'd0);
    check("rst_valid", 32'(ResultValid), 32'd0);
    check("rst_illegal", 32'(Illegal), 32'd0);
    check_flags("rst");

    run_op(5'd0,  4'd0,  16'd5,  16'd17,   1'b0);   // ADD -> 22
    run_op(5'd2,  4'd0,  16'd5,  16'd17,   1'b0);   // SUB -> 0xFFF4, borrow
    run_op(5'd3,  4'd0,  16'd5,  16'd17,   1'b0);   // SBC -> 0xFFF3
    run_op(5'd16, 4'd15, 16'd0,  16'hFFE9, 1'b0);   // ASRB by 15 -> 0xFFFF
    run_op(5'd18, 4'd0,  16'd17, 16'd17,   1'b0);   // CMP equal -> Z=1
    run_op(5'd25, 4'd3,  16'd9,  16'd9,    1'b1);   // illegal, plus busy OpValid
    run_op(5'd12, 4'd0,  16'd0,  16'h8001, 1'b0);   // LSL by 0 passes operand

    for (int i = 0; i < 150; i++) begin
      r_op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(19, 31))
                                         : 5'($urandom_range(0, 18));
      r_a  = 16'($urandom);
      r_b  = ($urandom_range(0, 5) == 0) ? r_a : 16'($urandom);
      run_op(r_op, 4'($urandom), r_a, r_b, 1'($urandom));
    end

    // Reset in the middle of EXEC aborts the op.
    OpCode = 5'd0; ShAmt = '0; op_a = 16'd5; op_b = 16'd17; OpValid = 1'b1;
    @(negedge Clock);
    OpValid = 1'b0;
    @(negedge Clock);
    check("midexec_en", 32'(ALUEnable), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    mdl_z = 1'b0; mdl_c = 1'b0; mdl_n = 1'b0;
    check("abort_ctrl", 32'(ctrl_vec), 32'd0);
    check("abort_en", 32'(ALUEnable), 32'd0);
    check("abort_ready", 32'(OpReady), 32'd1);
    check("abort_valid", 32'(ResultValid), 32'd0);
    check_flags("abort");
    repeat (SETTLE + 2) begin
      @(negedge Clock);
      check("abort_no_valid", 32'(ResultValid), 32'd0);
    end

    run_op(5'd1, 4'd0, 16'hFFFF, 16'h0001, 1'b0);   // ADC after reset, C=0 -> 0 with carry

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
